// File: rtl/usr_pkg.sv
// Shared opcode encoding and helpers for the universal shift register.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_RSVD = 3'b111
  } opcode_t;

  // Shift/rotate opcodes run for 'amount' clock steps; all others finish in one edge.
  function automatic logic is_multi(input opcode_t op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step next-value generator for the shift register.
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] data,
  input  logic             input_shift_right,
  input  logic             input_shift_left,
  output logic [WIDTH-1:0] next
);

  // Select the value the register takes after one step of 'op'.
  always_comb begin
    next = cur;
    case (op)
      OP_SHR:  next = {input_shift_right, cur[WIDTH-1:1]};
      OP_SHL:  next = {cur[WIDTH-2:0], input_shift_left};
      OP_LOAD: next = data;
      OP_ROR:  next = {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  next = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ASR:  next = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: next = cur;
    endcase
  end

endmodule

// File: rtl/universal_shift_register_n.sv
// Parametrised universal shift register with multi-step shift/rotate and busy/done handshake.
module universal_shift_register_n
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AMOUNT_W = 4
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic [2:0]          opcode,
  input  logic [AMOUNT_W-1:0] amount,
  input  logic [WIDTH-1:0]    data,
  input  logic                input_shift_right,
  input  logic                input_shift_left,
  output logic [WIDTH-1:0]    out,
  output logic                busy,
  output logic                done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_n;
  logic [AMOUNT_W-1:0] count_q, count_n;
  opcode_t             op_q, op_n;
  opcode_t             op_in;
  opcode_t             step_op;
  logic                done_q, done_n;
  logic [WIDTH-1:0]    out_q, next_val;

  assign op_in = opcode_t'(opcode);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .op                (step_op),
    .cur               (out_q),
    .data              (data),
    .input_shift_right (input_shift_right),
    .input_shift_left  (input_shift_left),
    .next              (next_val)
  );

  // State register: value, step counter, latched opcode, control state and done pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= OP_HOLD;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      op_q    <= op_n;
      done_q  <= done_n;
      out_q   <= next_val;
    end
  end

  // Next-state logic: the first step is applied on the accepting edge itself,
  // so the counter holds the steps remaining after that edge.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    op_n    = op_q;
    done_n  = 1'b0;
    step_op = OP_HOLD;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_multi(op_in)) begin
            if (amount != '0) begin
              step_op = op_in;
              op_n    = op_in;
              count_n = amount - AMOUNT_W'(1);
              if (amount > AMOUNT_W'(1)) state_n = RUN;
              else                       done_n  = 1'b1;
            end else begin
              done_n = 1'b1;
            end
          end else begin
            step_op = op_in;
            done_n  = 1'b1;
          end
        end
      end
      RUN: begin
        step_op = op_q;
        count_n = count_q - AMOUNT_W'(1);
        if (count_q == AMOUNT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic: busy reflects steps still pending after the current edge.
  always_comb begin
    out  = out_q;
    busy = (state_q == RUN);
    done = done_q;
  end

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Self-checking bench: behavioural model compared every cycle plus directed literal checks.
module tb_universal_shift_register_n;

  localparam int WIDTH    = 8;
  localparam int AMOUNT_W = 4;

  logic             clk = 1'b0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       opcode = 3'd0;
  logic [3:0]       amount = 4'd0;
  logic [7:0]       data = 8'd0;
  logic             input_shift_right = 1'b0;
  logic             input_shift_left = 1'b0;
  logic [7:0]       out;
  logic             busy;
  logic             done;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  universal_shift_register_n #(.WIDTH(WIDTH), .AMOUNT_W(AMOUNT_W)) dut (
    .clk               (clk),
    .clear             (clear),
    .start             (start),
    .opcode            (opcode),
    .amount            (amount),
    .data              (data),
    .input_shift_right (input_shift_right),
    .input_shift_left  (input_shift_left),
    .out               (out),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  // Reference model: register value, steps still to run, latched op, done pulse.
  bit [7:0] m_out = 8'd0;
  int       m_rem = 0;
  bit [2:0] m_op  = 3'd0;
  bit       m_done = 1'b0;

  function automatic bit multi(input bit [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
  endfunction

  function automatic bit [7:0] step1(input bit [2:0] op, input bit [7:0] v,
                                     input bit sr, input bit sl);
    case (op)
      3'd1: return (v >> 1) | (sr ? 8'h80 : 8'h00);
      3'd2: return (v << 1) | {7'd0, sl};
      3'd4: return (v >> 1) | ((v % 2) ? 8'h80 : 8'h00);
      3'd5: return (v << 1) | (v >> 7);
      3'd6: return (v >> 1) | (v & 8'h80);
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (clear) begin
      m_out = 8'd0;
      m_rem = 0;
      m_op  = 3'd0;
    end else if (m_rem > 0) begin
      m_out = step1(m_op, m_out, input_shift_right, input_shift_left);
      m_rem = m_rem - 1;
      m_done = (m_rem == 0);
    end else if (start) begin
      m_done = 1'b1;
      if (opcode == 3'd3) begin
        m_out = data;
      end else if (multi(opcode) && amount != 0) begin
        m_op  = opcode;
        m_out = step1(opcode, m_out, input_shift_right, input_shift_left);
        m_rem = int'(amount) - 1;
        m_done = (m_rem == 0);
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (out !== m_out) begin
        miscompares++;
        $display("FAIL out: got %02h expected %02h at %0t", out, m_out, $time);
      end
      vectors++;
      if (busy !== (m_rem > 0)) begin
        miscompares++;
        $display("FAIL busy: got %b expected %b at %0t", busy, (m_rem > 0), $time);
      end
      vectors++;
      if (done !== m_done) begin
        miscompares++;
        $display("FAIL done: got %b expected %b at %0t", done, m_done, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] d);
    start = 1'b1; opcode = op; amount = amt; data = d;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // 1. reset
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    checking = 1'b1;
    check_lit("reset_out", out, 8'h00);
    check_lit("reset_busy", {7'd0, busy}, 8'h00);
    check_lit("reset_done", {7'd0, done}, 8'h00);
    tick();
    tick();
    check_lit("idle_out", out, 8'h00);

    // 2. parallel load
    issue(3'b011, 4'd0, 8'hC5);
    check_lit("load_out", out, 8'hC5);
    check_lit("load_done", {7'd0, done}, 8'h01);
    check_lit("load_busy", {7'd0, busy}, 8'h00);
    tick();
    check_lit("load_done_pulse", {7'd0, done}, 8'h00);

    // 3. rotate left 3 with an ignored start while busy
    issue(3'b101, 4'd3, 8'h00);
    check_lit("rol_s1", out, 8'h8B);
    check_lit("rol_busy1", {7'd0, busy}, 8'h01);
    start = 1'b1; opcode = 3'b011; data = 8'hFF;
    tick();
    start = 1'b0;
    check_lit("rol_s2", out, 8'h17);
    check_lit("rol_busy2", {7'd0, busy}, 8'h01);
    tick();
    check_lit("rol_s3", out, 8'h2E);
    check_lit("rol_done", {7'd0, done}, 8'h01);
    check_lit("rol_busy3", {7'd0, busy}, 8'h00);
    tick();

    // 4. arithmetic shift right
    issue(3'b011, 4'd0, 8'h90);
    issue(3'b110, 4'd2, 8'h00);
    check_lit("asr_s1", out, 8'hC8);
    tick();
    check_lit("asr_s2", out, 8'hE4);
    check_lit("asr_done", {7'd0, done}, 8'h01);

    // 5. shift right 4 with serial 1, then zero-amount shift left
    issue(3'b011, 4'd0, 8'h00);
    input_shift_right = 1'b1;
    issue(3'b001, 4'd4, 8'h00);
    tick();
    tick();
    tick();
    input_shift_right = 1'b0;
    check_lit("shr_out", out, 8'hF0);
    check_lit("shr_done", {7'd0, done}, 8'h01);
    issue(3'b010, 4'd0, 8'h00);
    check_lit("shl0_out", out, 8'hF0);
    check_lit("shl0_done", {7'd0, done}, 8'h01);
    check_lit("shl0_busy", {7'd0, busy}, 8'h00);

    // 6. rotate right 10 aborted by clear after 3 steps
    issue(3'b011, 4'd0, 8'hC5);
    issue(3'b100, 4'd10, 8'h00);
    tick();
    tick();
    check_lit("ror_s3", out, 8'hB8);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_lit("abort_out", out, 8'h00);
    check_lit("abort_busy", {7'd0, busy}, 8'h00);
    check_lit("abort_done", {7'd0, done}, 8'h00);
    issue(3'b011, 4'd0, 8'h3C);
    check_lit("after_abort_load", out, 8'h3C);
    check_lit("after_abort_done", {7'd0, done}, 8'h01);

    // Random phase against the model
    for (int i = 0; i < 2000; i++) begin
      clear  = ($urandom_range(0, 59) == 0);
      start  = ($urandom_range(0, 2) != 0);
      opcode = 3'($urandom_range(0, 7));
      amount = 4'($urandom_range(0, 15));
      data   = 8'($urandom);
      input_shift_right = 1'($urandom);
      input_shift_left  = 1'($urandom);
      tick();
    end
    clear = 1'b0;
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/universal_shift_register_n.md
Name: universal_shift_register_n

Overview:
- Parametrised successor to the 4-bit universal shift register.
- Generic WIDTH; adds rotate and arithmetic-shift modes.
- Adds multi-step shift/rotate: one command executes AMOUNT single-bit steps, one per clock, with busy/done handshake.
- Serves as the shift/rotate datapath element for the ALU and serial-I/O blocks.

Parameters:
- WIDTH, 8: register width in bits (>=2).
- AMOUNT_W, 4: width of step-count field; max steps per command = 2^AMOUNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- opcode  in  3  operation select (see Behaviour).
- amount  in  AMOUNT_W  number of single-bit steps for shift/rotate ops.
- data  in  WIDTH  parallel load value.
- input_shift_right  in  1  serial input entering the MSB on shift right; sampled each step.
- input_shift_left  in  1  serial input entering the LSB on shift left; sampled each step.
- out  out  WIDTH  register contents.
- busy  out  1  high while steps remain after the current edge.
- done  out  1  one-cycle pulse; out holds the final result while done=1.

Behaviour:
- Opcodes:
  - 000 hold.
  - 001 shift right: out[i]<=out[i+1]; MSB<=input_shift_right.
  - 010 shift left: out[i]<=out[i-1]; LSB<=input_shift_left.
  - 011 parallel load: out<=data; amount ignored.
  - 100 rotate right: MSB<=old LSB.
  - 101 rotate left: LSB<=old MSB.
  - 110 arithmetic shift right: MSB keeps its value.
  - 111 reserved; behaves as hold.
- Reset: on any edge with clear=1, out=0, busy=0, done=0, internal step counter=0, latched opcode=000. clear overrides start and any in-progress command.
- IDLE (busy=0), start=1 at edge k:
  - Load, hold, reserved, or amount=0: out updated (or unchanged) at edge k; done=1 for the cycle after k; busy stays 0.
  - Shift/rotate with amount=N>=1: opcode latched; first step applied at edge k; counter<=N-1; busy<=1 iff N>1.
  - Each further edge applies one step and decrements the counter.
  - The final step lands at edge k+N-1, where done<=1 and busy<=0.
  - Total latency: N edges; done visible in cycle k+N.
- start while busy=1: ignored. opcode, amount and data changes are also ignored; only the latched opcode applies.
- Serial inputs are not latched. Each step uses the value present at that edge.
- amount > WIDTH is legal:
  - Rotates wrap modulo WIDTH.
  - Logical shifts fill entirely with the serial input.
  - ASR saturates to all-sign.
- done is a registered single-cycle pulse. A new start may be accepted in the same cycle done=1, since busy=0.
- No command and start=0: out holds.

Decomposition:
- Package usr_pkg: localparams for the 8 opcodes (OP_HOLD, OP_SHR, OP_SHL, OP_LOAD, OP_ROR, OP_ROL, OP_ASR, OP_RSVD) and a helper function returning 1 for multi-step opcodes.
- Sub-module usr_step: purely combinational one-step next-value generator. Inputs: opcode, current value, data, serial inputs. Output: next value. It generalises the per-bit mux4 into a WIDTH-wide 8-way select.
- The top-level holds the register, counter, latched opcode and busy/done logic.

Test Plan (WIDTH=8, AMOUNT_W=4):
1. clear=1 for 2 edges, then 0 -> out=0x00, busy=0, done=0. Idle cycles keep out=0x00.
2. start, opcode=011, data=0xC5 -> next cycle out=0xC5, done=1 for exactly 1 cycle, busy never high.
3. From 0xC5, start, opcode=101, amount=3:
   - out steps 0x8B, 0x17, 0x2E.
   - busy=1 for 2 cycles; done pulses with out=0x2E.
   - A second start during busy (opcode=011, data=0xFF) has no effect.
4. Load 0x90, then start, opcode=110, amount=2 -> 0xC8, then 0xE4; done with out=0xE4.
5. From 0x00, opcode=001, amount=4, input_shift_right=1 -> out=0xF0 after 4 steps. Then opcode=010, amount=0 -> done pulse next cycle, out stays 0xF0.
6. From 0xC5, opcode=100, amount=10; assert clear after 3 steps -> out=0x00, busy=0, no done pulse. A following load of 0x3C is accepted normally.
